// File: rtl/sprite_tex_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_tex_loader_if
//  Purpose  : Bundles the loader's three buses: the burst request channel to
//             the SDRAM read engine, the returned word stream, and the shared
//             texture-RAM load bus toward the sprite renderer.
//  Ports    : none (signal container)
//             req_*   burst request valid/ready with start address and length
//             src_*   returned RGB565 word stream with valid/ready
//             load_*  shared write data plus per-texture enable and address
//  Modports : master - the loader (drives requests, src_ready and load bus)
//             slave  - read engine / renderer side
//  Revision : 1.0  initial release
// ============================================================================
interface sprite_tex_loader_if;
  logic        req_valid;
  logic [23:0] req_addr;
  logic [15:0] req_len;
  logic        req_ready;

  logic        src_valid;
  logic [15:0] src_data;
  logic        src_ready;

  logic [15:0] load_data;
  logic        bird_load_en;
  logic [12:0] bird_load_addr;
  logic        pipe_load_en;
  logic [15:0] pipe_load_addr;
  logic        base_load_en;
  logic [13:0] base_load_addr;

  modport master (
    output req_valid, req_addr, req_len,
    input  req_ready,
    input  src_valid, src_data,
    output src_ready,
    output load_data,
    output bird_load_en, bird_load_addr,
    output pipe_load_en, pipe_load_addr,
    output base_load_en, base_load_addr
  );

  modport slave (
    input  req_valid, req_addr, req_len,
    output req_ready,
    output src_valid, src_data,
    input  src_ready,
    input  load_data,
    input  bird_load_en, bird_load_addr,
    input  pipe_load_en, pipe_load_addr,
    input  base_load_en, base_load_addr
  );
endinterface
`default_nettype wire

// File: rtl/sprite_tex_loader.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_tex_loader
//  Purpose  : Boot-time texture loader. On start it requests the bird, pipe
//             and ground textures from the SDRAM read engine in turn and
//             streams each returned word into the matching texture RAM.
//             A watchdog aborts the sequence if the stream stalls.
//  Ports    : clk, rst   clock and synchronous active-high reset
//             start      one-cycle pulse, honoured only in IDLE or ERR
//             bus        request / source stream / load bus (master side)
//             busy       sequence in progress
//             done       one-cycle pulse after the last ground word write
//             tex_ready  level, all textures loaded
//             error      level, stream timeout
//  Revision : 1.0  initial release
// ============================================================================
module sprite_tex_loader #(
  parameter logic [23:0] BIRD_SRC_ADDR = 24'h0C0000,
  parameter int unsigned BIRD_LEN      = 5250,
  parameter logic [23:0] PIPE_SRC_ADDR = 24'h0C2000,
  parameter int unsigned PIPE_LEN      = 40000,
  parameter logic [23:0] BASE_SRC_ADDR = 24'h0CC000,
  parameter int unsigned BASE_LEN      = 9600,
  parameter int unsigned TIMEOUT       = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  sprite_tex_loader_if.master        bus,
  output logic                       busy,
  output logic                       done,
  output logic                       tex_ready,
  output logic                       error
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    REQ_BIRD = 4'd1,
    LD_BIRD  = 4'd2,
    REQ_PIPE = 4'd3,
    LD_PIPE  = 4'd4,
    REQ_BASE = 4'd5,
    LD_BASE  = 4'd6,
    FIN      = 4'd7,
    ERR      = 4'd8
  } state_t;

  localparam logic [15:0] c_bird_len  = 16'(BIRD_LEN);
  localparam logic [15:0] c_pipe_len  = 16'(PIPE_LEN);
  localparam logic [15:0] c_base_len  = 16'(BASE_LEN);
  localparam logic [15:0] c_bird_last = 16'(BIRD_LEN - 1);
  localparam logic [15:0] c_pipe_last = 16'(PIPE_LEN - 1);
  localparam logic [15:0] c_base_last = 16'(BASE_LEN - 1);
  localparam logic [31:0] c_wd_last   = 32'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        req_valid_q, req_valid_d;
  logic [23:0] req_addr_q, req_addr_d;
  logic [15:0] req_len_q, req_len_d;
  logic        src_ready_q, src_ready_d;
  logic [15:0] load_data_q, load_data_d;
  logic        bird_en_q, bird_en_d;
  logic [12:0] bird_addr_q, bird_addr_d;
  logic        pipe_en_q, pipe_en_d;
  logic [15:0] pipe_addr_q, pipe_addr_d;
  logic        base_en_q, base_en_d;
  logic [13:0] base_addr_q, base_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tex_ready_q, tex_ready_d;
  logic        error_q, error_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] wd_q, wd_d;

  logic w_accept;
  logic w_req_fire;
  logic w_active;

  // src_ready_q is only ever set in LD states, so an accept implies LD_x.
  assign w_accept   = bus.src_valid && src_ready_q;
  assign w_req_fire = req_valid_q && bus.req_ready;
  assign w_active   = (state_q != IDLE) && (state_q != FIN) && (state_q != ERR);

  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_len_d   = req_len_q;
    src_ready_d = src_ready_q;
    load_data_d = load_data_q;
    bird_en_d   = 1'b0;
    bird_addr_d = bird_addr_q;
    pipe_en_d   = 1'b0;
    pipe_addr_d = pipe_addr_q;
    base_en_d   = 1'b0;
    base_addr_d = base_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tex_ready_d = tex_ready_q;
    error_d     = error_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;

    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_d     = REQ_BIRD;
          req_valid_d = 1'b1;
          req_addr_d  = BIRD_SRC_ADDR;
          req_len_d   = c_bird_len;
          busy_d      = 1'b1;
          tex_ready_d = 1'b0;
          error_d     = 1'b0;
          wd_d        = '0;
        end
      end

      REQ_BIRD, REQ_PIPE, REQ_BASE: begin
        if (w_req_fire) begin
          req_valid_d = 1'b0;
          src_ready_d = 1'b1;
          cnt_d       = '0;
          wd_d        = '0;
          state_d     = (state_q == REQ_BIRD) ? LD_BIRD :
                        (state_q == REQ_PIPE) ? LD_PIPE : LD_BASE;
        end
      end

      LD_BIRD: begin
        if (w_accept) begin
          load_data_d = bus.src_data;
          bird_addr_d = cnt_q[12:0];
          bird_en_d   = 1'b1;
          cnt_d       = cnt_q + 16'd1;
          wd_d        = '0;
          if (cnt_q == c_bird_last) begin
            // Next request rises together with this word's write enable.
            state_d     = REQ_PIPE;
            src_ready_d = 1'b0;
            req_valid_d = 1'b1;
            req_addr_d  = PIPE_SRC_ADDR;
            req_len_d   = c_pipe_len;
          end
        end
      end

      LD_PIPE: begin
        if (w_accept) begin
          load_data_d = bus.src_data;
          pipe_addr_d = cnt_q;
          pipe_en_d   = 1'b1;
          cnt_d       = cnt_q + 16'd1;
          wd_d        = '0;
          if (cnt_q == c_pipe_last) begin
            state_d     = REQ_BASE;
            src_ready_d = 1'b0;
            req_valid_d = 1'b1;
            req_addr_d  = BASE_SRC_ADDR;
            req_len_d   = c_base_len;
          end
        end
      end

      LD_BASE: begin
        if (w_accept) begin
          load_data_d = bus.src_data;
          base_addr_d = cnt_q[13:0];
          base_en_d   = 1'b1;
          cnt_d       = cnt_q + 16'd1;
          wd_d        = '0;
          if (cnt_q == c_base_last) begin
            // done/tex_ready land in the same cycle as the final write.
            state_d     = FIN;
            src_ready_d = 1'b0;
            done_d      = 1'b1;
            tex_ready_d = 1'b1;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Watchdog: any request/load cycle without a handshake counts toward
    // the timeout; the abort overrides the hold-state defaults above.
    if (w_active && !w_req_fire && !w_accept) begin
      if (wd_q == c_wd_last) begin
        state_d     = ERR;
        error_d     = 1'b1;
        req_valid_d = 1'b0;
        src_ready_d = 1'b0;
        busy_d      = 1'b0;
        wd_d        = '0;
      end else begin
        wd_d = wd_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      src_ready_q <= 1'b0;
      load_data_q <= '0;
      bird_en_q   <= 1'b0;
      bird_addr_q <= '0;
      pipe_en_q   <= 1'b0;
      pipe_addr_q <= '0;
      base_en_q   <= 1'b0;
      base_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tex_ready_q <= 1'b0;
      error_q     <= 1'b0;
      cnt_q       <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_len_q   <= req_len_d;
      src_ready_q <= src_ready_d;
      load_data_q <= load_data_d;
      bird_en_q   <= bird_en_d;
      bird_addr_q <= bird_addr_d;
      pipe_en_q   <= pipe_en_d;
      pipe_addr_q <= pipe_addr_d;
      base_en_q   <= base_en_d;
      base_addr_q <= base_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tex_ready_q <= tex_ready_d;
      error_q     <= error_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
    end
  end

  assign bus.req_valid      = req_valid_q;
  assign bus.req_addr       = req_addr_q;
  assign bus.req_len        = req_len_q;
  assign bus.src_ready      = src_ready_q;
  assign bus.load_data      = load_data_q;
  assign bus.bird_load_en   = bird_en_q;
  assign bus.bird_load_addr = bird_addr_q;
  assign bus.pipe_load_en   = pipe_en_q;
  assign bus.pipe_load_addr = pipe_addr_q;
  assign bus.base_load_en   = base_en_q;
  assign bus.base_load_addr = base_addr_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign tex_ready          = tex_ready_q;
  assign error              = error_q;

endmodule
`default_nettype wire

// File: doc/sprite_tex_loader.md
# sprite_tex_loader

Boot-time texture loader that sits directly upstream of the sprite renderer's texture RAM write ports. On a start pulse it issues three burst read requests to the SDRAM read engine: bird, then pipe, then ground texture. It streams the returned 16-bit words onto the renderer's shared load-data bus, driving the matching per-texture write enable and word address. It reports completion, or a timeout error if the SDRAM stream stalls.

## Interface

Parameters:
- BIRD_SRC_ADDR, 24'h0C0000, SDRAM word address of bird texture (3 frames × 50×35)
- BIRD_LEN, 5250, bird word count
- PIPE_SRC_ADDR, 24'h0C2000, SDRAM word address of pipe texture (80×500)
- PIPE_LEN, 40000, pipe word count (all sent; renderer keeps the first 4000)
- BASE_SRC_ADDR, 24'h0CC000, SDRAM word address of ground texture (64×150)
- BASE_LEN, 9600, ground word count
- TIMEOUT, 1000000, max cycles without an accepted word before error

Ports:
- clk  in  1  50 MHz system clock; also the renderer's load clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load sequence when idle
- req_valid  out  1  burst request valid
- req_addr  out  24  burst start word address
- req_len  out  16  burst length in words
- req_ready  in  1  read engine accepts the request
- src_valid  in  1  returned word valid
- src_data  in  16  returned RGB565 word
- src_ready  out  1  loader accepts the word
- load_data  out  16  shared write data to all texture RAMs
- bird_load_en  out  1  bird RAM write enable
- bird_load_addr  out  13  bird RAM address
- pipe_load_en  out  1  pipe RAM write enable
- pipe_load_addr  out  16  pipe RAM address
- base_load_en  out  1  ground RAM write enable
- base_load_addr  out  14  ground RAM address
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when all three textures are written
- tex_ready  out  1  level; all textures valid; cleared by rst or an accepted start
- error  out  1  level; stream timeout; cleared by rst or an accepted start

## Operation

- FSM states: IDLE, REQ_BIRD, LD_BIRD, REQ_PIPE, LD_PIPE, REQ_BASE, LD_BASE, FIN, ERR.
- IDLE or ERR, start=1 → REQ_BIRD. In the same cycle, tex_ready and error clear. start is ignored in all other states.
- REQ_x: req_valid=1, with req_addr = x_SRC_ADDR and req_len = x_LEN (truncated to 16 bits). Hold until req_ready=1, then go to LD_x. The word counter clears to 0 on that transition.
- LD_x: src_ready=1 only in LD states.
  - On each src_valid&&src_ready: register load_data=src_data, set x_addr=counter, assert x_load_en for exactly the following cycle, then increment counter.
  - Once counter==x_LEN-1 is accepted, move to the next REQ state (or FIN after ground).
- FIN: pulse done, set tex_ready=1, return to IDLE.
- Enables are mutually exclusive. Addresses hold their last value when enables are low. load_data holds its last value.
- Watchdog: counts cycles in any REQ/LD state with no handshake. It clears on every accepted request or word.
  - Reaching TIMEOUT → ERR: error=1, req_valid=0, src_ready=0, busy=0.
  - Words arriving in ERR are not written.
- busy=1 in every state except IDLE and ERR.
- Counter is 16 bits wide; address outputs are the low 13/16/14 counter bits.

## Timing

- Reset values:
  - 0: req_valid, req_addr, req_len, src_ready, load_data, all *_load_en, all *_load_addr, busy, done, tex_ready, error.
  - State IDLE; counter and watchdog 0.
- start → req_valid high on the next cycle.
- Accepted word → write enable and data/address valid 1 cycle later. There are no bubbles: back-to-back src_valid gives back-to-back writes.
- Segment switch: the last word's enable occurs in the same cycle as the next req_valid rises.
- Last ground word accepted at cycle N: base_load_en at N+1, done at N+1, tex_ready from N+1.
- rst mid-sequence returns everything to reset values on the next edge. An in-flight enable is dropped.

## Test plan

- Full load, src_valid always 1, req_ready immediate:
  - 3 requests (0x0C0000/5250, 0x0C2000/40000, 0x0CC000/9600).
  - bird_load_en high for exactly 5250 cycles, addresses 0..5249.
  - pipe addresses 0..39999; ground addresses 0..9599.
  - done single pulse, tex_ready=1.
- Data integrity: src_data = counter ^ 16'hA5A5 → every write's load_data matches its address ^ 16'hA5A5. No duplicated or skipped addresses under random src_valid gaps (≈30% duty).
- Request backpressure: req_ready held low 20 cycles in REQ_PIPE → req_valid and req_addr stable. src_ready=0 and no writes until the handshake completes.
- Timeout (TIMEOUT=100 in bench): stop src_valid after bird word 1000 → error=1 after 100 idle cycles, busy=0. Later valid words are not written. A new start clears error and restarts at bird address 0.
- start pulsed during LD_PIPE → ignored; the sequence completes with exactly one done.
- rst asserted at pipe word 500 → all outputs 0 next cycle, state IDLE. A subsequent start reloads from bird address 0.
